// File: rtl/pwm_duty_seq.sv
// pwm_duty_seq -- duty-cycle sequencer for a downstream 4-bit PWM stage.
//
// A prescaler divides clk into base ticks, and a tick counter divides those
// ticks by 2^rate to form step events. On each step event the FSM advances
// the duty value: a static value, a breathe ramp with a dwell at each
// extreme, or a free-running sawtooth.
//
// Parameters:
//   TICK_DIV  clk cycles per base tick
//   DWELL     step events held at each breathe extreme
// Ports:
//   clk      in   sole clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   en       in   enable; 0 freezes all state and forces step low
//   mode     in   [1:0] 00 static, 01 breathe, 10 sawtooth, 11 hold
//   sw       in   [3:0] static duty used in mode 00
//   rate     in   [1:0] step period = 2^rate base ticks
//   duty     out  [3:0] registered duty value
//   dir      out  registered; 1 rising/static, 0 falling
//   step     out  registered one-cycle pulse per duty step event
module pwm_duty_seq #(
    parameter int TICK_DIV = 500000,
    parameter int DWELL    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic [3:0] sw,
    input  logic [1:0] rate,
    output logic [3:0] duty,
    output logic       dir,
    output logic       step
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DWELL < 1) ? 1 : $clog2(DWELL + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW:0]   DWELL_V    = (DW + 1)'(DWELL);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_UP       = 3'd1,
        S_TOP_HOLD = 3'd2,
        S_DOWN     = 3'd3,
        S_BOT_HOLD = 3'd4,
        S_SAW      = 3'd5
    } state_t;

    logic [PW-1:0] presc_r;
    logic [2:0]    tcnt_r;
    logic [DW-1:0] dwell_r;
    logic [DW-1:0] dwell_n_s;
    logic [DW:0]   dwell_inc_s;
    logic          hold_done_s;
    state_t        state_r;
    state_t        state_n_s;
    logic [3:0]    duty_r;
    logic [3:0]    duty_n_s;
    logic          dir_r;
    logic          step_r;
    logic          active_s;
    logic          tick_s;
    logic [3:0]    last_s;
    logic          step_ev_s;

    // Timebase runs only when enabled and not in the hold mode.
    assign active_s  = en && (mode != 2'b11);
    assign tick_s    = active_s && (presc_r == PRESC_LAST);
    // Last tick-counter value for the current rate; kept 4 bits wide so 2^3 fits.
    assign last_s    = (4'd1 << rate) - 4'd1;
    // A counter at or above the (possibly just lowered) modulus wraps and steps.
    assign step_ev_s = tick_s && ({1'b0, tcnt_r} >= last_s);

    assign dwell_inc_s = {1'b0, dwell_r} + (DW + 1)'(1);
    assign hold_done_s = (dwell_inc_s >= DWELL_V);

    // Prescaler and tick counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_r <= '0;
            tcnt_r  <= 3'd0;
        end else if (active_s) begin
            if (presc_r == PRESC_LAST) begin
                presc_r <= '0;
            end else begin
                presc_r <= presc_r + PW'(1);
            end
            if (tick_s) begin
                if (step_ev_s) begin
                    tcnt_r <= 3'd0;
                end else begin
                    tcnt_r <= tcnt_r + 3'd1;
                end
            end
        end
    end

    // Next-state, next-duty and dwell logic of the sequencer FSM.
    always_comb begin
        state_n_s = state_r;
        duty_n_s  = duty_r;
        dwell_n_s = dwell_r;
        if (!en) begin
            state_n_s = state_r;
        end else begin
            case (mode)
                2'b00: begin
                    state_n_s = S_IDLE;
                    duty_n_s  = sw;
                end
                2'b01: begin
                    case (state_r)
                        S_IDLE: state_n_s = S_UP;
                        S_UP: begin
                            if (step_ev_s) begin
                                if (duty_r == 4'd15) begin
                                    // Entered already at the top: no increment.
                                    state_n_s = S_TOP_HOLD;
                                    dwell_n_s = '0;
                                end else if (duty_r == 4'd14) begin
                                    duty_n_s  = 4'd15;
                                    state_n_s = S_TOP_HOLD;
                                    dwell_n_s = '0;
                                end else begin
                                    duty_n_s = duty_r + 4'd1;
                                end
                            end else begin
                                state_n_s = S_UP;
                            end
                        end
                        S_TOP_HOLD: begin
                            if (step_ev_s) begin
                                if (hold_done_s) begin
                                    state_n_s = S_DOWN;
                                    dwell_n_s = '0;
                                end else begin
                                    dwell_n_s = dwell_inc_s[DW-1:0];
                                end
                            end else begin
                                state_n_s = S_TOP_HOLD;
                            end
                        end
                        S_DOWN: begin
                            if (step_ev_s) begin
                                if (duty_r <= 4'd1) begin
                                    // Clamp: the ramp never wraps below zero.
                                    duty_n_s  = 4'd0;
                                    state_n_s = S_BOT_HOLD;
                                    dwell_n_s = '0;
                                end else begin
                                    duty_n_s = duty_r - 4'd1;
                                end
                            end else begin
                                state_n_s = S_DOWN;
                            end
                        end
                        S_BOT_HOLD: begin
                            if (step_ev_s) begin
                                if (hold_done_s) begin
                                    state_n_s = S_UP;
                                    dwell_n_s = '0;
                                end else begin
                                    dwell_n_s = dwell_inc_s[DW-1:0];
                                end
                            end else begin
                                state_n_s = S_BOT_HOLD;
                            end
                        end
                        // Coming from sawtooth: one IDLE cycle first.
                        default: state_n_s = S_IDLE;
                    endcase
                end
                2'b10: begin
                    case (state_r)
                        S_IDLE: state_n_s = S_SAW;
                        S_SAW: begin
                            if (step_ev_s) begin
                                duty_n_s = duty_r + 4'd1;
                            end else begin
                                duty_n_s = duty_r;
                            end
                        end
                        // Coming from a breathe state: one IDLE cycle first.
                        default: state_n_s = S_IDLE;
                    endcase
                end
                default: state_n_s = state_r;
            endcase
        end
    end

    // Sequencer registers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
            duty_r  <= 4'd0;
            dwell_r <= '0;
            dir_r   <= 1'b1;
            step_r  <= 1'b0;
        end else if (en) begin
            state_r <= state_n_s;
            duty_r  <= duty_n_s;
            dwell_r <= dwell_n_s;
            dir_r   <= !((state_n_s == S_DOWN) || (state_n_s == S_BOT_HOLD));
            step_r  <= step_ev_s && ((mode == 2'b01) || (mode == 2'b10));
        end else begin
            step_r  <= 1'b0;
        end
    end

    assign duty = duty_r;
    assign dir  = dir_r;
    assign step = step_r;

endmodule

// File: tb/tb_pwm_duty_seq.sv
module tb_pwm_duty_seq;

    localparam int TICK_DIV = 4;
    localparam int DWELL    = 2;
    localparam int BUDGET   = 100;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] sw;
    logic [1:0] rate;
    logic [3:0] duty;
    logic       dir;
    logic       step;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       rst;
        logic [1:0] mode;
        logic [1:0] rate;
        int         gap;
        logic [3:0] duty;
        logic       dir;
    } vec_t;

    vec_t vecs[$];

    pwm_duty_seq #(.TICK_DIV(TICK_DIV), .DWELL(DWELL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .mode    (mode),
        .sw      (sw),
        .rate    (rate),
        .duty    (duty),
        .dir     (dir),
        .step    (step)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] m, input logic [1:0] r);
        reset_n = 1'b0;
        en      = 1'b1;
        mode    = m;
        rate    = r;
        sw      = 4'd0;
        cyc();
        check("reset_duty", int'(duty), 0);
        check("reset_dir", int'(dir), 1);
        check("reset_step", int'(step), 0);
        reset_n = 1'b1;
    endtask

    // Cycles until step is seen high; 0 means the budget expired.
    task automatic wait_step(input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            cyc();
            if (step === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            tests++;
            fails++;
            $display("FAIL wait_step: no step within %0d cycles", budget);
        end
    endtask

    task automatic frozen_cycles(input int ncyc, input int exp_duty, input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < ncyc; i++) begin
            cyc();
            if (duty !== 4'(exp_duty) || step !== 1'b0) bad++;
        end
        check(name, bad, 0);
        check({name, "_duty"}, int'(duty), exp_duty);
    endtask

    initial begin
        int n;
        int nsteps;
        vec_t v;

        // Breathe from reset, rate 0: one step per base tick (4 cycles).
        for (int k = 1; k <= 35; k++) begin
            v.rst  = (k == 1);
            v.mode = 2'b01;
            v.rate = 2'd0;
            v.gap  = 4;
            if (k <= 15)      v.duty = 4'(k);
            else if (k <= 17) v.duty = 4'd15;
            else if (k <= 32) v.duty = 4'(32 - k);
            else if (k <= 34) v.duty = 4'd0;
            else              v.duty = 4'd1;
            v.dir = (k <= 16 || k >= 34) ? 1'b1 : 1'b0;
            vecs.push_back(v);
        end
        // Sawtooth, rate 1: one step per 8 cycles, 14,15,0,1 wrap at the end.
        for (int k = 1; k <= 17; k++) begin
            v.rst  = (k == 1);
            v.mode = 2'b10;
            v.rate = 2'd1;
            v.gap  = 8;
            v.duty = 4'(k % 16);
            v.dir  = 1'b1;
            vecs.push_back(v);
        end

        reset_n = 1'b0;
        en      = 1'b0;
        mode    = 2'b00;
        rate    = 2'd0;
        sw      = 4'd0;
        #1;
        check("async_reset_duty", int'(duty), 0);

        // Static mode.
        do_reset(2'b00, 2'd0);
        sw = 4'd9;
        cyc();
        check("static_duty9", int'(duty), 9);
        nsteps = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (step === 1'b1) nsteps++;
        end
        check("static_no_step", nsteps, 0);
        check("static_dir", int'(dir), 1);
        sw = 4'd3;
        cyc();
        check("static_duty3", int'(duty), 3);
        en = 1'b0;
        sw = 4'd12;
        cyc();
        cyc();
        check("static_en0_frozen", int'(duty), 3);
        en = 1'b1;
        cyc();
        check("static_en1_follow", int'(duty), 12);

        // Table-driven breathe and sawtooth sequences.
        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset(vecs[i].mode, vecs[i].rate);
            mode = vecs[i].mode;
            rate = vecs[i].rate;
            wait_step(BUDGET, n);
            check($sformatf("vec%0d_gap", i), n, vecs[i].gap);
            check($sformatf("vec%0d_duty", i), int'(duty), int'(vecs[i].duty));
            check($sformatf("vec%0d_dir", i), int'(dir), int'(vecs[i].dir));
        end

        // Hold mode mid-ramp at duty 7, two cycles into the prescaler period.
        do_reset(2'b01, 2'd0);
        for (int k = 0; k < 7; k++) wait_step(BUDGET, n);
        check("hold_pre_duty", int'(duty), 7);
        cyc();
        cyc();
        mode = 2'b11;
        frozen_cycles(50, 7, "hold_frozen");
        check("hold_dir", int'(dir), 1);
        mode = 2'b01;
        wait_step(BUDGET, n);
        check("hold_resume_gap", n, 2);
        check("hold_resume_duty", int'(duty), 8);

        // Same freeze with en=0; a mode change while disabled is ignored.
        cyc();
        en = 1'b0;
        frozen_cycles(40, 8, "en0_frozen");
        mode = 2'b00;
        sw   = 4'd4;
        frozen_cycles(10, 8, "en0_mode_ignored");
        mode = 2'b01;
        en   = 1'b1;
        wait_step(BUDGET, n);
        check("en_resume_gap", n, 3);
        check("en_resume_duty", int'(duty), 9);

        // Reset mid-DOWN at duty 6 acts without a clock edge.
        do_reset(2'b01, 2'd0);
        for (int k = 0; k < 26; k++) wait_step(BUDGET, n);
        check("down_pre_duty", int'(duty), 6);
        check("down_pre_dir", int'(dir), 0);
        reset_n = 1'b0;
        #1;
        check("midreset_duty", int'(duty), 0);
        check("midreset_dir", int'(dir), 1);
        check("midreset_step", int'(step), 0);
        cyc();
        reset_n = 1'b1;
        wait_step(BUDGET, n);
        check("restart_gap", n, 4);
        check("restart_duty", int'(duty), 1);

        // Rate 3 -> 0 with the tick counter at 5.
        do_reset(2'b01, 2'd3);
        nsteps = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (step === 1'b1) nsteps++;
        end
        check("rate3_no_step", nsteps, 0);
        rate = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            wait_step(BUDGET, n);
            check($sformatf("ratechg%0d_gap", k), n, 4);
            check($sformatf("ratechg%0d_duty", k), int'(duty), k);
        end

        // Mode change to static mid-ramp.
        mode = 2'b00;
        sw   = 4'd5;
        cyc();
        check("to_static_duty", int'(duty), 5);
        check("to_static_dir", int'(dir), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
